// File: rtl/snake_pkg.sv
// snake_pkg: game/collision encodings shared with the game FSM, plus BCD helper
package snake_pkg;

    localparam logic [1:0] IDLE            = 2'b00;
    localparam logic [1:0] PLAY            = 2'b01;
    localparam logic [1:0] GAME_OVER       = 2'b11;

    localparam logic [1:0] NONE            = 2'b00;
    localparam logic [1:0] COLLISION       = 2'b01;
    localparam logic [1:0] APPLE_COLLECTED = 2'b10;

    // Saturating 2-digit BCD increment: 99 stays 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return v == 8'h99 ? v :
               v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/digit_glyph.sv
// digit_glyph: 3x5 glyph ROM lookup, lit flag for one cell of a BCD digit
module digit_glyph (
    input  logic [3:0] digit,
    input  logic [1:0] col,
    input  logic [2:0] row,
    output logic       lit
);

    logic [14:0] glyph;
    logic [15:0] padded;
    logic [3:0]  idx;

    // Row-major, MSB is row 0 col 0; codes A-F render blank
    always_comb begin
        case (digit)
            4'd0:    glyph = 15'b111_101_101_101_111;
            4'd1:    glyph = 15'b010_110_010_010_111;
            4'd2:    glyph = 15'b111_001_111_100_111;
            4'd3:    glyph = 15'b111_001_111_001_111;
            4'd4:    glyph = 15'b101_101_111_001_001;
            4'd5:    glyph = 15'b111_100_111_001_111;
            4'd6:    glyph = 15'b111_100_111_101_111;
            4'd7:    glyph = 15'b111_001_001_001_001;
            4'd8:    glyph = 15'b111_101_111_101_111;
            4'd9:    glyph = 15'b111_101_111_001_111;
            default: glyph = '0;
        endcase
    end

    assign padded = {glyph, 1'b0};
    assign idx    = {1'b0, row} * 4'd3 + {2'b00, col};
    assign lit    = col != 2'd3 && row < 3'd5 && padded[4'd15 - idx];

endmodule

// File: rtl/score_tracker.sv
// score_tracker: BCD score / high score keeping and registered glyph pixel output
module score_tracker
    import snake_pkg::*;
#(
    parameter int         BIT        = 10,
    parameter int         SCALE_LOG2 = 2,
    parameter int         SCORE_X    = 16,
    parameter int         HIGH_X     = 560,
    parameter int         DIGIT_Y    = 8,
    parameter logic [2:0] RGB_SCORE  = 3'b111,
    parameter logic [2:0] RGB_HIGH   = 3'b110
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     game_state,
    input  logic [1:0]     collision_state,
    input  logic [BIT-1:0] x_pos,
    input  logic [BIT-1:0] y_pos,
    output logic           score_active,
    output logic [2:0]     rgb,
    output logic [7:0]     score_bcd,
    output logic [7:0]     high_bcd
);

    localparam int CELL = 1 << SCALE_LOG2;

    logic           apple_q;
    logic [1:0]     prev_state;
    logic           apple_rise;
    logic           round_start;
    logic           over_entry;
    logic [3:0]     digit [4];
    logic [3:0]     lit;
    logic [BIT-1:0] dy;
    logic [BIT-1:0] row;

    assign apple_rise  = collision_state == APPLE_COLLECTED && !apple_q;
    assign round_start = prev_state == IDLE && game_state == PLAY;
    assign over_entry  = prev_state != GAME_OVER && game_state == GAME_OVER;

    assign digit[0] = score_bcd[7:4];
    assign digit[1] = score_bcd[3:0];
    assign digit[2] = high_bcd[7:4];
    assign digit[3] = high_bcd[3:0];

    assign dy  = y_pos - BIT'(DIGIT_Y);
    assign row = dy >> SCALE_LOG2;

    // Pixels left of / above a window wrap to large offsets and fall outside
    for (genvar g = 0; g < 4; g++) begin : g_digit
        localparam int X = (g < 2 ? SCORE_X : HIGH_X) + (g % 2) * 4 * CELL;
        logic [BIT-1:0] dx;
        logic [BIT-1:0] col;
        logic           in_win;
        logic           glyph_lit;
        assign dx     = x_pos - BIT'(X);
        assign col    = dx >> SCALE_LOG2;
        assign in_win = col < BIT'(3) && row < BIT'(5);
        digit_glyph u_glyph (
            .digit (digit[g]),
            .col   (col[1:0]),
            .row   (row[2:0]),
            .lit   (glyph_lit)
        );
        assign lit[g] = in_win && glyph_lit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            apple_q      <= 1'b0;
            prev_state   <= IDLE;
            score_bcd    <= '0;
            high_bcd     <= '0;
            score_active <= 1'b0;
            rgb          <= '0;
        end else begin
            apple_q    <= collision_state == APPLE_COLLECTED;
            prev_state <= game_state;
            if (round_start)
                score_bcd <= '0;
            else if (apple_rise && game_state == PLAY)
                score_bcd <= bcd_inc(score_bcd);
            // Valid BCD orders the same as binary, so a plain compare is tens-then-ones
            if (over_entry && score_bcd > high_bcd)
                high_bcd <= score_bcd;
            score_active <= |lit;
            rgb          <= |lit[1:0] ? RGB_SCORE : |lit[3:2] ? RGB_HIGH : 3'b000;
        end
    end

endmodule
